// File: rtl/frac_clk_pkg.sv
// frac_clk_pkg
// Shared constants, the config request record and a helper that converts a
// target output frequency into a phase-accumulator increment.
//   ACC_W_DEFAULT : default accumulator width
//   cfg_req_t     : {ch, incr, phase}, sized for the widest supported build
//   incr_for()    : round(f_out * 2^acc_w / f_ref)
package frac_clk_pkg;

  localparam int ACC_W_DEFAULT = 24;
  localparam int CH_W_MAX      = 4;   // up to 16 channels
  localparam int ACC_W_MAX     = 32;

  typedef struct packed {
    logic [CH_W_MAX-1:0]  ch;
    logic [ACC_W_MAX-1:0] incr;
    logic [ACC_W_MAX-1:0] phase;
  } cfg_req_t;

  // Rounded to the nearest increment so the long-run error is at most half an LSB.
  function automatic longint unsigned incr_for(input longint unsigned f_ref_hz,
                                               input longint unsigned f_out_hz,
                                               input int              acc_w = ACC_W_DEFAULT);
    return ((f_out_hz << acc_w) + (f_ref_hz >> 1)) / f_ref_hz;
  endfunction

endpackage

// File: rtl/frac_clk_ch.sv
// frac_clk_ch
// One phase-accumulator channel with a shadowed, glitch-free retune.
// Ports:
//   refclk   : clock
//   rst      : synchronous active-high reset
//   wr_en    : load shadow increment/phase and mark the update pending
//   wr_incr  : new increment (0 stops the channel)
//   wr_phase : accumulator value loaded when the update is applied
//   pending  : an update is waiting for its apply point
//   en_out   : registered one-cycle pulse on accumulator overflow
//   clk_sq   : registered accumulator MSB
module frac_clk_ch #(
  parameter int               ACC_W        = 24,
  parameter logic [ACC_W-1:0] DEFAULT_INCR = ACC_W'(393216)
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_incr,
  input  logic [ACC_W-1:0] wr_phase,
  output logic             pending,
  output logic             en_out,
  output logic             clk_sq
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] incr_reg;
  logic [ACC_W-1:0] sh_incr_reg;
  logic [ACC_W-1:0] sh_phase_reg;
  logic             pending_reg;
  logic             en_reg;
  logic             sq_reg;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;
  logic [ACC_W-1:0] acc_next;

  always_comb begin
    sum      = {1'b0, acc_reg} + {1'b0, incr_reg};
    carry    = sum[ACC_W];
    // Swap only on an overflow so the square wave never gets a runt phase;
    // a stopped channel never overflows, so it swaps straight away.
    apply    = pending_reg && (carry || (incr_reg == '0));
    acc_next = apply ? sh_phase_reg : sum[ACC_W-1:0];
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      acc_reg      <= '0;
      incr_reg     <= DEFAULT_INCR;
      sh_incr_reg  <= '0;
      sh_phase_reg <= '0;
      pending_reg  <= 1'b0;
      en_reg       <= 1'b0;
      sq_reg       <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      en_reg  <= carry;                 // the overflow pulse survives an apply
      sq_reg  <= acc_next[ACC_W-1];     // tracks the accumulator actually stored
      if (apply) begin
        incr_reg    <= sh_incr_reg;
        pending_reg <= 1'b0;
      end
      // The top only writes while this channel is idle, so this never races apply.
      if (wr_en) begin
        sh_incr_reg  <= wr_incr;
        sh_phase_reg <= wr_phase;
        pending_reg  <= 1'b1;
      end
    end
  end

  assign pending = pending_reg;
  assign en_out  = en_reg;
  assign clk_sq  = sq_reg;

endmodule

// File: rtl/frac_clk_en_gen.sv
// frac_clk_en_gen
// Multi-channel fractional clock-enable generator.
// Ports:
//   refclk    : reference clock, the only clock
//   rst       : synchronous active-high reset
//   cfg_valid : config request valid
//   cfg_ready : request accepted when high with cfg_valid (combinational on cfg_ch)
//   cfg_ch    : target channel; out-of-range channels are accepted and dropped
//   cfg_incr  : new increment, 0 disables the channel
//   cfg_phase : accumulator value loaded at the apply point
//   en_out    : one-cycle enable pulse per channel
//   clk_sq    : registered accumulator MSB per channel
//   locked    : no update pending for LOCK_CYCLES consecutive cycles
module frac_clk_en_gen
  import frac_clk_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          ACC_W        = ACC_W_DEFAULT,
  parameter int unsigned DEFAULT_INCR = 393216,
  parameter int          LOCK_CYCLES  = 16,
  localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_incr,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] en_out,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              locked
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr_en;
  logic              any_pending;
  logic [LOCK_W-1:0] lock_cnt_reg;
  logic              locked_reg;

  // Busy only if the addressed channel exists and still holds an update.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((cfg_ch == CH_W'(i)) && pending[i]) begin
        cfg_ready = 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_en[gi] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));

      frac_clk_ch #(
        .ACC_W        (ACC_W),
        .DEFAULT_INCR (ACC_W'(DEFAULT_INCR))
      ) u_ch (
        .refclk   (refclk),
        .rst      (rst),
        .wr_en    (wr_en[gi]),
        .wr_incr  (cfg_incr),
        .wr_phase (cfg_phase),
        .pending  (pending[gi]),
        .en_out   (en_out[gi]),
        .clk_sq   (clk_sq[gi])
      );
    end
  endgenerate

  assign any_pending = |pending;

  // locked also looks at pending directly so it drops on the edge after an accept.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else begin
      if (any_pending) begin
        lock_cnt_reg <= '0;
      end else if (lock_cnt_reg != LOCK_W'(LOCK_CYCLES)) begin
        lock_cnt_reg <= lock_cnt_reg + 1'b1;
      end
      locked_reg <= !any_pending && (lock_cnt_reg == LOCK_W'(LOCK_CYCLES));
    end
  end

  assign locked = locked_reg;

endmodule

// File: tb/tb_frac_clk_en_gen.sv
module tb_frac_clk_en_gen;
  import frac_clk_pkg::*;

  localparam int          NUM_CH   = 4;
  localparam int          ACC_W    = 24;
  localparam int unsigned DEF_INCR = 393216;

  logic              refclk    = 1'b0;
  logic              rst       = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_ch    = '0;
  logic [ACC_W-1:0]  cfg_incr  = '0;
  logic [ACC_W-1:0]  cfg_phase = '0;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] clk_sq;
  logic              locked;

  always #5 refclk = ~refclk;

  frac_clk_en_gen #(
    .NUM_CH       (NUM_CH),
    .ACC_W        (ACC_W),
    .DEFAULT_INCR (DEF_INCR),
    .LOCK_CYCLES  (16)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_incr  (cfg_incr),
    .cfg_phase (cfg_phase),
    .en_out    (en_out),
    .clk_sq    (clk_sq),
    .locked    (locked)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // edges since the last reset edge

  // Closed-form expectation per channel: after edge `anchor` the accumulator
  // holds `phase` and advances by `incr` each edge.
  longint m_incr[NUM_CH];
  longint m_phase[NUM_CH];
  int     m_anchor[NUM_CH];
  bit     m_en0[NUM_CH];
  // Hand-computed apply points waiting to take effect.
  bit     s_act[NUM_CH];
  int     s_cyc[NUM_CH];
  longint s_incr[NUM_CH];
  longint s_phase[NUM_CH];
  bit     s_en0[NUM_CH];

  typedef struct packed {
    int       issue;
    cfg_req_t req;
    int       apply_cyc;
    logic     en_at_apply;
  } op_t;

  typedef struct packed {
    int   at;
    logic exp;
  } lock_vec_t;

  op_t       ops[4];
  lock_vec_t lock_tbl[6];
  bit        lock_tbl_en = 1'b0;

  function automatic op_t make_op(input int issue, input int ch, input longint inc,
                                  input longint ph, input int apply_cyc, input logic e0);
    op_t o;
    o.issue       = issue;
    o.req.ch      = CH_W_MAX'(ch);
    o.req.incr    = ACC_W_MAX'(inc);
    o.req.phase   = ACC_W_MAX'(ph);
    o.apply_cyc   = apply_cyc;
    o.en_at_apply = e0;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic model_default();
    for (int i = 0; i < NUM_CH; i++) begin
      m_incr[i]   = DEF_INCR;
      m_phase[i]  = 0;
      m_anchor[i] = 0;
      m_en0[i]    = 1'b0;
      s_act[i]    = 1'b0;
    end
  endtask

  task automatic schedule(input int ch, input int at, input longint inc,
                          input longint ph, input bit e0);
    s_act[ch]   = 1'b1;
    s_cyc[ch]   = at;
    s_incr[ch]  = inc;
    s_phase[ch] = ph;
    s_en0[ch]   = e0;
  endtask

  task automatic tick();
    logic [NUM_CH-1:0] e_en;
    logic [NUM_CH-1:0] e_sq;
    longint t;
    step();
    cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s_act[i] && (s_cyc[i] == cyc)) begin
        m_incr[i]   = s_incr[i];
        m_phase[i]  = s_phase[i];
        m_anchor[i] = cyc;
        m_en0[i]    = s_en0[i];
        s_act[i]    = 1'b0;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      t = m_phase[i] + longint'(cyc - m_anchor[i]) * m_incr[i];
      if (cyc == m_anchor[i]) e_en[i] = m_en0[i];
      else                    e_en[i] = ((t >> ACC_W) != ((t - m_incr[i]) >> ACC_W));
      e_sq[i] = t[ACC_W-1];
    end
    $display("cyc=%0d en_out=%b clk_sq=%b locked=%b", cyc, en_out, clk_sq, locked);
    chk("en_out", en_out, e_en);
    chk("clk_sq", clk_sq, e_sq);
    if (lock_tbl_en) begin
      for (int k = 0; k < 6; k++) begin
        if (lock_tbl[k].at == cyc) chk("locked", locked, lock_tbl[k].exp);
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    int pulses[NUM_CH];
    int last[NUM_CH];
    int bad[NUM_CH];

    // Config operations: {issue cycle, request, hand-computed apply edge, en at apply}
    ops[0] = make_op(1280, 1, 64'd4194304, 64'd0,       1323, 1'b1); // waits for ch1 carry
    ops[1] = make_op(1364, 2, 64'd0,       64'd8388608, 1366, 1'b1); // ch2 carry is next edge
    ops[2] = make_op(1380, 2, 64'd8388608, 64'd0,       1382, 1'b0); // stopped channel: immediate
    ops[3] = make_op(1400, 0, 64'd1048576, 64'hF00000,  1408, 1'b1); // phase preload

    lock_tbl[0] = '{at: 16,   exp: 1'b0};
    lock_tbl[1] = '{at: 17,   exp: 1'b1};
    lock_tbl[2] = '{at: 1281, exp: 1'b1};
    lock_tbl[3] = '{at: 1282, exp: 1'b0};
    lock_tbl[4] = '{at: 1339, exp: 1'b0};
    lock_tbl[5] = '{at: 1340, exp: 1'b1};

    chk("incr_for", incr_for(64'd50_000_000, 64'd1_171_875), 64'd393216);

    // Reset state after the first edge with rst high
    step();
    chk("rst_en_out", en_out, 0);
    chk("rst_clk_sq", clk_sq, 0);
    chk("rst_locked", locked, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    step();
    rst = 1'b0;
    cyc = 0;
    model_default();
    lock_tbl_en = 1'b1;

    // Defaults: 30 pulses in 1280 cycles, spacing 42/43
    for (int i = 0; i < NUM_CH; i++) begin
      pulses[i] = 0;
      last[i]   = 0;
      bad[i]    = 0;
    end
    for (int k = 0; k < 1280; k++) begin
      tick();
      for (int i = 0; i < NUM_CH; i++) begin
        if (en_out[i]) begin
          if (pulses[i] > 0 && (cyc - last[i]) != 42 && (cyc - last[i]) != 43) bad[i]++;
          pulses[i]++;
          last[i] = cyc;
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      chk("pulse_count", pulses[i], 30);
      chk("pulse_spacing_bad", bad[i], 0);
    end

    // Table-driven retunes
    for (int n = 0; n < 4; n++) begin
      run_to(ops[n].issue);
      cfg_ch    = ops[n].req.ch[1:0];
      cfg_incr  = ops[n].req.incr[ACC_W-1:0];
      cfg_phase = ops[n].req.phase[ACC_W-1:0];
      chk("ready_idle", cfg_ready, 1);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      schedule(int'(ops[n].req.ch), ops[n].apply_cyc, longint'(ops[n].req.incr),
               longint'(ops[n].req.phase), ops[n].en_at_apply);
      while (cyc < ops[n].apply_cyc) begin
        chk("ready_pending", cfg_ready, 0);
        tick();
      end
      chk("ready_applied", cfg_ready, 1);
    end

    // Phase preload on ch0: carry at apply edge, then again one cycle later
    chk("phase_apply_pulse", en_out[0], 1);
    tick();
    chk("phase_first_pulse", en_out[0], 1);
    tick();
    chk("phase_gap", en_out[0], 0);

    // Back-to-back requests to ch3
    run_to(1443);
    cfg_ch    = 2'd3;
    cfg_incr  = 24'h200000;
    cfg_phase = 24'h000000;
    chk("b2b_ready_first", cfg_ready, 1);
    cfg_valid = 1'b1;
    tick();
    schedule(3, 1451, 64'h200000, 64'd0, 1'b1);
    cfg_incr  = 24'h400000;
    cfg_phase = 24'h800000;
    while (cyc < 1451) begin
      chk("b2b_busy1", cfg_ready, 0);
      tick();
    end
    chk("b2b_free1", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    schedule(3, 1459, 64'h400000, 64'h800000, 1'b1);
    while (cyc < 1459) begin
      chk("b2b_busy2", cfg_ready, 0);
      tick();
    end
    chk("b2b_free2", cfg_ready, 1);

    // Reset while ch1 holds an update
    run_to(1483);
    cfg_ch    = 2'd1;
    cfg_incr  = 24'h100000;
    cfg_phase = 24'h123456;
    chk("rst_mid_ready", cfg_ready, 1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("rst_mid_pending", cfg_ready, 0);
    rst = 1'b1;
    lock_tbl_en = 1'b0;
    step();
    chk("rst2_en_out", en_out, 0);
    chk("rst2_clk_sq", clk_sq, 0);
    chk("rst2_locked", locked, 0);
    chk("rst2_cfg_ready", cfg_ready, 1);
    rst = 1'b0;
    cyc = 0;
    model_default();
    for (int k = 0; k < 200; k++) begin
      tick();
      if (cyc == 16) chk("rst2_locked_16", locked, 0);
      if (cyc == 17) chk("rst2_locked_17", locked, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
